// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sequencer: effect ids, FSM state
// encoding and the note-table field widths.
package sfx_pkg;

    localparam logic [1:0] SFX_SHOOT   = 2'd0;
    localparam logic [1:0] SFX_HIT     = 2'd1;
    localparam logic [1:0] SFX_EXPLODE = 2'd2;
    localparam logic [1:0] SFX_UFO     = 2'd3;

    localparam int unsigned SFX_ID_W   = 32'd2;
    localparam int unsigned SFX_STEP_W = 32'd3;
    localparam int unsigned SFX_DUR_W  = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } sfx_state_e;

endpackage

// File: rtl/sfx_rom.sv
// Note table for every sound effect: (id, step) -> {freq, dur in ticks}.
// dur == 0 ends the effect; freq == 0 with dur > 0 is a rest.
module sfx_rom
    import sfx_pkg::*;
#(
    parameter int unsigned FREQ_W = 32'd24,
    parameter int unsigned ID_W   = SFX_ID_W,
    parameter int unsigned STEP_W = SFX_STEP_W
) (
    input  logic [ID_W-1:0]      id,
    input  logic [STEP_W-1:0]    step,
    output logic [FREQ_W-1:0]    freq,
    output logic [SFX_DUR_W-1:0] dur
);

    logic [15:0] note_freq_s;
    logic [15:0] note_dur_s;

    // Effect note lookup; anything not listed is a terminator.
    always_comb begin
        note_freq_s = 16'd0;
        note_dur_s  = 16'd0;
        case (id)
            SFX_SHOOT: begin
                case (step)
                    3'd0:    {note_freq_s, note_dur_s} = {16'd440, 16'd2};
                    3'd1:    {note_freq_s, note_dur_s} = {16'd880, 16'd1};
                    default: {note_freq_s, note_dur_s} = {16'd0, 16'd0};
                endcase
            end
            SFX_HIT: begin
                case (step)
                    3'd0:    {note_freq_s, note_dur_s} = {16'd220, 16'd1};
                    3'd1:    {note_freq_s, note_dur_s} = {16'd0, 16'd1};
                    3'd2:    {note_freq_s, note_dur_s} = {16'd110, 16'd2};
                    default: {note_freq_s, note_dur_s} = {16'd0, 16'd0};
                endcase
            end
            SFX_EXPLODE: begin
                case (step)
                    3'd0:    {note_freq_s, note_dur_s} = {16'd60, 16'd4};
                    3'd1:    {note_freq_s, note_dur_s} = {16'd50, 16'd4};
                    3'd2:    {note_freq_s, note_dur_s} = {16'd40, 16'd4};
                    default: {note_freq_s, note_dur_s} = {16'd0, 16'd0};
                endcase
            end
            SFX_UFO: begin
                case (step)
                    3'd0:    {note_freq_s, note_dur_s} = {16'd100, 16'd3};
                    default: {note_freq_s, note_dur_s} = {16'd0, 16'd0};
                endcase
            end
            default: {note_freq_s, note_dur_s} = {16'd0, 16'd0};
        endcase
    end

    assign freq = FREQ_W'(note_freq_s);
    assign dur  = note_dur_s;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: latches request pulses, plays the highest-priority
// effect note by note on a free-running tick, and lets equal/higher ids preempt.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 32'd12000000,
    parameter int unsigned TICK_HZ   = 32'd1000,
    parameter int unsigned FREQ_W    = 32'd24,
    parameter int unsigned N_SFX     = 32'd4,
    parameter int unsigned MAX_STEPS = 32'd8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [N_SFX-1:0]             i_req,
    output logic [FREQ_W-1:0]            o_freq,
    output logic                         o_busy,
    output logic [$clog2(N_SFX)-1:0]     o_sfx_id,
    output logic [$clog2(MAX_STEPS)-1:0] o_step
);

    localparam int unsigned ID_W     = $clog2(N_SFX);
    localparam int unsigned SW       = $clog2(MAX_STEPS);
    localparam int unsigned SCNT_W   = SW + 32'd1;
    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned TCNT_W   = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;

    sfx_state_e            state_r, state_nx_s;
    logic [TCNT_W-1:0]     tick_cnt_r, tick_cnt_nx_s;
    logic                  tick_s;
    logic [N_SFX-1:0]      pending_r, pending_nx_s, clr_s;
    logic [ID_W-1:0]       cur_id_r, cur_id_nx_s, hi_id_s;
    logic                  hi_valid_s, preempt_s;
    logic [SCNT_W-1:0]     step_r, step_nx_s;
    logic [SFX_DUR_W-1:0]  dur_cnt_r, dur_cnt_nx_s, rom_dur_s;
    logic [FREQ_W-1:0]     freq_r, freq_nx_s, rom_freq_s;
    logic                  busy_r, busy_nx_s;

    sfx_rom #(
        .FREQ_W (FREQ_W),
        .ID_W   (ID_W),
        .STEP_W (SW)
    ) u_rom (
        .id   (cur_id_r),
        .step (step_r[SW-1:0]),
        .freq (rom_freq_s),
        .dur  (rom_dur_s)
    );

    // Free-running tick divider and highest-pending-request priority encoder.
    always_comb begin
        tick_s        = (tick_cnt_r == TCNT_W'(TICK_DIV - 32'd1));
        tick_cnt_nx_s = tick_s ? '0 : tick_cnt_r + TCNT_W'(32'd1);
        hi_valid_s    = |pending_r;
        hi_id_s       = '0;
        for (int k = 0; k < N_SFX; k++) begin
            hi_id_s = pending_r[k] ? ID_W'(k) : hi_id_s;
        end
        preempt_s = hi_valid_s && (hi_id_s >= cur_id_r);
    end

    // Next-state and datapath: launch/preempt, note load and duration countdown.
    always_comb begin
        state_nx_s   = state_r;
        cur_id_nx_s  = cur_id_r;
        step_nx_s    = step_r;
        dur_cnt_nx_s = dur_cnt_r;
        freq_nx_s    = freq_r;
        clr_s        = '0;
        case (state_r)
            ST_IDLE: begin
                freq_nx_s = '0;
                if (hi_valid_s) begin
                    cur_id_nx_s = hi_id_s;
                    step_nx_s   = '0;
                    clr_s       = N_SFX'(32'd1) << hi_id_s;
                    state_nx_s  = ST_LOAD;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (preempt_s) begin
                    cur_id_nx_s = hi_id_s;
                    step_nx_s   = '0;
                    clr_s       = N_SFX'(32'd1) << hi_id_s;
                    state_nx_s  = ST_LOAD;
                end else if ((step_r == SCNT_W'(MAX_STEPS)) || (rom_dur_s == 16'd0)) begin
                    freq_nx_s   = '0;
                    state_nx_s  = ST_IDLE;
                end else begin
                    freq_nx_s    = rom_freq_s;
                    dur_cnt_nx_s = rom_dur_s;
                    state_nx_s   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (preempt_s) begin
                    cur_id_nx_s = hi_id_s;
                    step_nx_s   = '0;
                    clr_s       = N_SFX'(32'd1) << hi_id_s;
                    state_nx_s  = ST_LOAD;
                end else if (tick_s) begin
                    // Treating 0 like 1 keeps the counter from ever wrapping below zero.
                    if (dur_cnt_r <= 16'd1) begin
                        dur_cnt_nx_s = 16'd0;
                        step_nx_s    = step_r + SCNT_W'(32'd1);
                        state_nx_s   = ST_LOAD;
                    end else begin
                        dur_cnt_nx_s = dur_cnt_r - 16'd1;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            default: begin
                freq_nx_s  = '0;
                state_nx_s = ST_IDLE;
            end
        endcase
        pending_nx_s = (pending_r & ~clr_s) | i_req;
        busy_nx_s    = (state_nx_s != ST_IDLE);
    end

    // State and datapath registers; every output is taken straight from a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= '0;
            pending_r  <= '0;
            cur_id_r   <= '0;
            step_r     <= '0;
            dur_cnt_r  <= '0;
            freq_r     <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            tick_cnt_r <= tick_cnt_nx_s;
            pending_r  <= pending_nx_s;
            cur_id_r   <= cur_id_nx_s;
            step_r     <= step_nx_s;
            dur_cnt_r  <= dur_cnt_nx_s;
            freq_r     <= freq_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    assign o_freq   = freq_r;
    assign o_busy   = busy_r;
    assign o_sfx_id = cur_id_r;
    assign o_step   = step_r[SW-1:0];

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with a 10-cycle tick (CLK_HZ=100, TICK_HZ=10).
module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [23:0] freq;
    logic        busy;
    logic [1:0]  sfx_id;
    logic [2:0]  step;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    sfx_sequencer #(.CLK_HZ(100), .TICK_HZ(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_freq(freq), .o_busy(busy), .o_sfx_id(sfx_id), .o_step(step)
    );

    // Expected tick phase: counter 0..9, wraps on the tick edge, cleared by reset.
    always @(posedge clk) begin
        if (rst) m_cnt <= 0;
        else     m_cnt <= (m_cnt == 9) ? 0 : m_cnt + 1;
    end

    task automatic pulse(input logic [3:0] m);
        @(negedge clk); req = m;
        @(negedge clk); req = 4'h0;
    endtask

    task automatic run_len(input logic [23:0] val, output int len);
        len = 0;
        while (freq === val && len < 300) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; req = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++; if (freq !== 24'd0) begin n_fail++; $display("FAIL reset_freq: got %0d expected 0", freq); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        n_cmp++; if (sfx_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", sfx_id); end
        n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL reset_step: got %0d expected 0", step); end
        rst = 1'b0; req = 4'h0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || freq !== 24'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL reset_pending: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_single();
        int c, len;
        pulse(4'h1);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_pend_busy: got %0d expected 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_load_busy: got %0d expected 1", busy); end
        n_cmp++; if (freq !== 24'd0) begin n_fail++; $display("FAIL single_load_freq: got %0d expected 0", freq); end
        n_cmp++; if (sfx_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", sfx_id); end
        @(negedge clk);
        n_cmp++; if (freq !== 24'd440) begin n_fail++; $display("FAIL single_first: got %0d expected 440", freq); end
        c = m_cnt;
        run_len(24'd440, len);
        n_cmp++; if (len !== 21 - c) begin n_fail++; $display("FAIL single_440_len: got %0d expected %0d", len, 21 - c); end
        n_cmp++; if (freq !== 24'd880) begin n_fail++; $display("FAIL single_second: got %0d expected 880", freq); end
        n_cmp++; if (step !== 3'd1) begin n_fail++; $display("FAIL single_step1: got %0d expected 1", step); end
        run_len(24'd880, len);
        n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL single_880_len: got %0d expected 10", len); end
        n_cmp++; if (freq !== 24'd0) begin n_fail++; $display("FAIL single_end_freq: got %0d expected 0", freq); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy: got %0d expected 0", busy); end
    endtask

    task automatic test_preempt();
        int c, len, bad;
        pulse(4'h1);
        repeat (2) @(negedge clk);
        n_cmp++; if (freq !== 24'd440) begin n_fail++; $display("FAIL pre_start: got %0d expected 440", freq); end
        repeat (4) @(negedge clk);
        pulse(4'h8);
        @(negedge clk);
        n_cmp++; if (sfx_id !== 2'd3) begin n_fail++; $display("FAIL pre_id: got %0d expected 3", sfx_id); end
        n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL pre_step: got %0d expected 0", step); end
        @(negedge clk);
        n_cmp++; if (freq !== 24'd100) begin n_fail++; $display("FAIL pre_freq: got %0d expected 100", freq); end
        c = m_cnt;
        run_len(24'd100, len);
        n_cmp++; if (len !== 31 - c) begin n_fail++; $display("FAIL pre_100_len: got %0d expected %0d", len, 31 - c); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pre_end_busy: got %0d expected 0", busy); end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || freq !== 24'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL pre_no_resume: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_deferred();
        int c, len;
        pulse(4'h8);
        repeat (2) @(negedge clk);
        n_cmp++; if (freq !== 24'd100) begin n_fail++; $display("FAIL def_start: got %0d expected 100", freq); end
        c = m_cnt;
        len = 0;
        while (freq === 24'd100 && len < 300) begin
            req = (len == 5) ? 4'h1 : 4'h0;
            len++;
            @(negedge clk);
        end
        req = 4'h0;
        n_cmp++; if (len !== 31 - c) begin n_fail++; $display("FAIL def_100_len: got %0d expected %0d", len, 31 - c); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL def_gap_busy: got %0d expected 0", busy); end
        n_cmp++; if (freq !== 24'd0) begin n_fail++; $display("FAIL def_gap_freq: got %0d expected 0", freq); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL def_load_busy: got %0d expected 1", busy); end
        n_cmp++; if (sfx_id !== 2'd0) begin n_fail++; $display("FAIL def_load_id: got %0d expected 0", sfx_id); end
        @(negedge clk);
        n_cmp++; if (freq !== 24'd440) begin n_fail++; $display("FAIL def_440: got %0d expected 440", freq); end
        c = m_cnt;
        run_len(24'd440, len);
        n_cmp++; if (len !== 21 - c) begin n_fail++; $display("FAIL def_440_len: got %0d expected %0d", len, 21 - c); end
        run_len(24'd880, len);
        n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL def_880_len: got %0d expected 10", len); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL def_end_busy: got %0d expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int c, len;
        pulse(4'h9);
        repeat (2) @(negedge clk);
        n_cmp++; if (freq !== 24'd100) begin n_fail++; $display("FAIL sim_first_freq: got %0d expected 100", freq); end
        n_cmp++; if (sfx_id !== 2'd3) begin n_fail++; $display("FAIL sim_first_id: got %0d expected 3", sfx_id); end
        repeat (12) @(negedge clk);
        pulse(4'h8);
        @(negedge clk);
        n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL ret3_step: got %0d expected 0", step); end
        n_cmp++; if (freq !== 24'd100) begin n_fail++; $display("FAIL ret3_hold: got %0d expected 100", freq); end
        @(negedge clk);
        c = m_cnt;
        run_len(24'd100, len);
        n_cmp++; if (len !== 31 - c) begin n_fail++; $display("FAIL ret3_len: got %0d expected %0d", len, 31 - c); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_gap_busy: got %0d expected 0", busy); end
        @(negedge clk);
        n_cmp++; if (sfx_id !== 2'd0) begin n_fail++; $display("FAIL sim_second_id: got %0d expected 0", sfx_id); end
        @(negedge clk);
        n_cmp++; if (freq !== 24'd440) begin n_fail++; $display("FAIL sim_second_freq: got %0d expected 440", freq); end
        run_len(24'd440, len);
        n_cmp++; if (step !== 3'd1) begin n_fail++; $display("FAIL ret0_pre_step: got %0d expected 1", step); end
        repeat (3) @(negedge clk);
        pulse(4'h1);
        @(negedge clk);
        n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL ret0_step: got %0d expected 0", step); end
        n_cmp++; if (freq !== 24'd880) begin n_fail++; $display("FAIL ret0_hold: got %0d expected 880", freq); end
        @(negedge clk);
        n_cmp++; if (freq !== 24'd440) begin n_fail++; $display("FAIL ret0_freq: got %0d expected 440", freq); end
        c = m_cnt;
        run_len(24'd440, len);
        n_cmp++; if (len !== 21 - c) begin n_fail++; $display("FAIL ret0_440_len: got %0d expected %0d", len, 21 - c); end
        run_len(24'd880, len);
        n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL ret0_880_len: got %0d expected 10", len); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ret0_end_busy: got %0d expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int len, bad;
        pulse(4'h1);
        repeat (2) @(negedge clk);
        run_len(24'd440, len);
        n_cmp++; if (freq !== 24'd880) begin n_fail++; $display("FAIL rst_mid_pre: got %0d expected 880", freq); end
        repeat (3) @(negedge clk);
        req = 4'h2;
        @(negedge clk); req = 4'h0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++; if (freq !== 24'd0) begin n_fail++; $display("FAIL rst_mid_freq: got %0d expected 0", freq); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0d expected 0", busy); end
        n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL rst_mid_step: got %0d expected 0", step); end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || freq !== 24'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_no_resume: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_preempt();
        test_deferred();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
